w0rm_core_writeback: RTL and testbench

Writeback stage of the W0RM core: collects completed results from the ALU and the memory unit and drives the register file's single write port (`port_write_addr/enable/data`). It arbitrates the two producers, buffers ALU results that lose arbitration in a small FIFO, and keeps a pending-load scoreboard (`reg_busy`) that decode uses to stall on registers with outstanding loads. It sits between the execute/memory stages and the register file write port.

---
 rtl/w0rm_core_pkg.sv | 20 ++
 rtl/w0rm_core_wb_fifo.sv | 50 +++++
 rtl/w0rm_core_writeback.sv | 110 +++++++++++
 tb/tb_w0rm_core_writeback.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/w0rm_core_pkg.sv
// Shared W0RM core definitions used by the writeback stage.
//   DATA_WIDTH     register/result width
//   NUM_REGISTERS  architectural register count
//   REG_ADDR_BITS  register address width
//   wb_entry_t     buffered writeback entry {dest, data}
package w0rm_core_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned NUM_REGISTERS = 16;
    localparam int unsigned REG_ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]    reg_data_t;

    typedef struct packed {
        reg_addr_t dest;
        reg_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/w0rm_core_wb_fifo.sv
// Small synchronous FIFO holding ALU results that lost write-port arbitration.
//   clk, reset   clock, synchronous active-high reset
//   flush        drop all entries (overrides push/pop)
//   push, entry  write entry at tail
//   pop          advance head
//   count        number of valid entries
//   head         entry at head (valid when count != 0)
module w0rm_core_wb_fifo
    import w0rm_core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  wb_entry_t           entry,
    input  logic                pop,
    output logic [CNT_BITS-1:0] count,
    output wb_entry_t           head
);

    wb_entry_t           storage [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Data array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) storage[wr_ptr] <= entry;
    end

    assign head = storage[rd_ptr];

endmodule

// File: rtl/w0rm_core_writeback.sv
// W0RM writeback stage: arbitrates ALU and memory results onto the register
// file write port, buffers losing ALU results, and tracks pending loads.
//   clk, reset          clock, synchronous active-high reset
//   flush               squash buffered and incoming ALU results
//   alu_result_*        ALU result valid/ready handshake with dest/data
//   mem_result_*        load data return (always accepted)
//   load_issue*         load issued this cycle and its destination
//   port_write_*        registered register-file write port
//   reg_busy            per-register outstanding-load scoreboard
//   wb_idle             nothing buffered, pending or being written
module w0rm_core_writeback
    import w0rm_core_pkg::*;
#(
    parameter int unsigned ALU_BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alu_result_valid,
    output logic                     alu_result_ready,
    input  logic [REG_ADDR_BITS-1:0] alu_result_dest,
    input  logic [DATA_WIDTH-1:0]    alu_result_data,
    input  logic                     mem_result_valid,
    input  logic [REG_ADDR_BITS-1:0] mem_result_dest,
    input  logic [DATA_WIDTH-1:0]    mem_result_data,
    input  logic                     load_issue,
    input  logic [REG_ADDR_BITS-1:0] load_issue_dest,
    output logic                     port_write_enable,
    output logic [REG_ADDR_BITS-1:0] port_write_addr,
    output logic [DATA_WIDTH-1:0]    port_write_data,
    output logic [NUM_REGISTERS-1:0] reg_busy,
    output logic                     wb_idle
);

    localparam int unsigned CNT_BITS = $clog2(ALU_BUF_DEPTH + 1);

    logic [CNT_BITS-1:0]      fifo_count;
    wb_entry_t                fifo_head;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     alu_xfer;
    logic                     alu_bypass;
    logic                     wr_en_next;
    wb_entry_t                wr_entry_next;
    logic [NUM_REGISTERS-1:0] busy_next;

    w0rm_core_wb_fifo #(
        .DEPTH (ALU_BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (fifo_push),
        .entry ('{dest: alu_result_dest, data: alu_result_data}),
        .pop   (fifo_pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Ready looks only at the registered count, so a full FIFO popping this cycle stays not-ready.
    assign fifo_empty       = (fifo_count == '0);
    assign alu_result_ready = (fifo_count < CNT_BITS'(ALU_BUF_DEPTH)) && !flush;
    assign alu_xfer         = alu_result_valid && alu_result_ready;

    // Write-port arbitration: mem result, then FIFO head, then ALU bypass.
    always_comb begin
        fifo_pop      = 1'b0;
        alu_bypass    = 1'b0;
        wr_en_next    = 1'b0;
        wr_entry_next = '{dest: port_write_addr, data: port_write_data};
        if (mem_result_valid) begin
            wr_en_next    = 1'b1;
            wr_entry_next = '{dest: mem_result_dest, data: mem_result_data};
        end else if (!fifo_empty && !flush) begin
            fifo_pop      = 1'b1;
            wr_en_next    = 1'b1;
            wr_entry_next = fifo_head;
        end else if (alu_xfer && fifo_empty) begin
            alu_bypass    = 1'b1;
            wr_en_next    = 1'b1;
            wr_entry_next = '{dest: alu_result_dest, data: alu_result_data};
        end
        fifo_push = alu_xfer && !alu_bypass;
    end

    // Scoreboard: clear on returning load, set on issue; set applied last so it wins.
    always_comb begin
        busy_next = reg_busy;
        if (mem_result_valid) busy_next[mem_result_dest] = 1'b0;
        if (load_issue)       busy_next[load_issue_dest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_write_enable <= 1'b0;
            port_write_addr   <= '0;
            port_write_data   <= '0;
            reg_busy          <= '0;
        end else begin
            port_write_enable <= wr_en_next;
            port_write_addr   <= wr_entry_next.dest;
            port_write_data   <= wr_entry_next.data;
            reg_busy          <= busy_next;
        end
    end

    assign wb_idle = fifo_empty && (reg_busy == '0) && !port_write_enable;

endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Self-checking bench for w0rm_core_writeback: cycle-by-cycle vector table
// plus a hand-written back-to-back bypass burst.
module tb_w0rm_core_writeback;
    import w0rm_core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        alu_result_valid = 1'b0;
    logic        alu_result_ready;
    logic [3:0]  alu_result_dest = 4'd0;
    logic [31:0] alu_result_data = 32'd0;
    logic        mem_result_valid = 1'b0;
    logic [3:0]  mem_result_dest = 4'd0;
    logic [31:0] mem_result_data = 32'd0;
    logic        load_issue = 1'b0;
    logic [3:0]  load_issue_dest = 4'd0;
    logic        port_write_enable;
    logic [3:0]  port_write_addr;
    logic [31:0] port_write_data;
    logic [15:0] reg_busy;
    logic        wb_idle;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    w0rm_core_writeback #(
        .ALU_BUF_DEPTH (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .alu_result_valid  (alu_result_valid),
        .alu_result_ready  (alu_result_ready),
        .alu_result_dest   (alu_result_dest),
        .alu_result_data   (alu_result_data),
        .mem_result_valid  (mem_result_valid),
        .mem_result_dest   (mem_result_dest),
        .mem_result_data   (mem_result_data),
        .load_issue        (load_issue),
        .load_issue_dest   (load_issue_dest),
        .port_write_enable (port_write_enable),
        .port_write_addr   (port_write_addr),
        .port_write_data   (port_write_data),
        .reg_busy          (reg_busy),
        .wb_idle           (wb_idle)
    );

    // Inputs for one cycle; ready is expected before the edge, the rest after it.
    typedef struct {
        logic        rst;
        logic        fl;
        logic        av;
        logic [3:0]  ad;
        logic [31:0] adat;
        logic        mv;
        logic [3:0]  md;
        logic [31:0] mdat;
        logic        li;
        logic [3:0]  lid;
        logic        chk_rdy;
        logic        e_rdy;
        logic        e_we;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        logic [15:0] e_busy;
        logic        e_idle;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst   fl    av    ad    adat           mv    md     mdat          li    lid   chk   rdy   we    addr   data           busy     idle
        // reset
        vecs.push_back('{1'b1,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b0,1'b0,1'b0,4'd0, 32'h0,        16'h0000,1'b1});
        // single ALU result bypasses straight to the port
        vecs.push_back('{1'b0,1'b0,1'b1,4'd3,32'hDEADBEEF, 1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b1,4'd3, 32'hDEADBEEF, 16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd3, 32'hDEADBEEF, 16'h0000,1'b1});
        // load to r5, returns 3 cycles later alongside ALU r2
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b1,4'd5,1'b1,1'b1,1'b0,4'd3, 32'hDEADBEEF, 16'h0020,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd3, 32'hDEADBEEF, 16'h0020,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd3, 32'hDEADBEEF, 16'h0020,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd2,32'hA2A2A2A2, 1'b1,4'd5, 32'h1234,   1'b0,4'd0,1'b1,1'b1,1'b1,4'd5, 32'h1234,     16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b1,4'd2, 32'hA2A2A2A2, 16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd2, 32'hA2A2A2A2, 16'h0000,1'b1});
        // mem every cycle x4 with ALU every cycle: FIFO fills, ready drops, then drains in order
        vecs.push_back('{1'b0,1'b0,1'b1,4'd1,32'h11,       1'b1,4'd8, 32'h80,     1'b0,4'd0,1'b1,1'b1,1'b1,4'd8, 32'h80,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd2,32'h12,       1'b1,4'd9, 32'h90,     1'b0,4'd0,1'b1,1'b1,1'b1,4'd9, 32'h90,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd3,32'h13,       1'b1,4'd10,32'hA0,     1'b0,4'd0,1'b1,1'b0,1'b1,4'd10,32'hA0,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd3,32'h13,       1'b1,4'd11,32'hB0,     1'b0,4'd0,1'b1,1'b0,1'b1,4'd11,32'hB0,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd3,32'h13,       1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b0,1'b1,4'd1, 32'h11,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd3,32'h13,       1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b1,4'd2, 32'h12,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b1,4'd3, 32'h13,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd3, 32'h13,       16'h0000,1'b1});
        // fill FIFO with 2 entries, then flush alongside mem r7
        vecs.push_back('{1'b0,1'b0,1'b1,4'd4,32'h14,       1'b1,4'd12,32'hC0,     1'b0,4'd0,1'b1,1'b1,1'b1,4'd12,32'hC0,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd5,32'h15,       1'b1,4'd13,32'hD0,     1'b0,4'd0,1'b1,1'b1,1'b1,4'd13,32'hD0,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,4'd6,32'h16,       1'b1,4'd7, 32'h77,     1'b0,4'd0,1'b1,1'b0,1'b1,4'd7, 32'h77,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd7, 32'h77,       16'h0000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd7, 32'h77,       16'h0000,1'b1});
        // issue and return of r4 in the same cycle: set wins
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd4, 32'h44,     1'b1,4'd4,1'b1,1'b1,1'b1,4'd4, 32'h44,       16'h0010,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd4, 32'h44,       16'h0010,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd4, 32'h45,     1'b0,4'd0,1'b1,1'b1,1'b1,4'd4, 32'h45,       16'h0000,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd4, 32'h45,       16'h0000,1'b1});
        // build full FIFO and busy=0x00F0, then reset with everything active
        vecs.push_back('{1'b0,1'b0,1'b1,4'd1,32'h21,       1'b1,4'd9, 32'h99,     1'b1,4'd4,1'b1,1'b1,1'b1,4'd9, 32'h99,       16'h0010,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,4'd2,32'h22,       1'b1,4'd10,32'h9A,     1'b1,4'd5,1'b1,1'b1,1'b1,4'd10,32'h9A,       16'h0030,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd11,32'h9B,     1'b1,4'd6,1'b1,1'b0,1'b1,4'd11,32'h9B,       16'h0070,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd12,32'h9C,     1'b1,4'd7,1'b1,1'b0,1'b1,4'd12,32'h9C,       16'h00F0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,4'd3,32'h33,       1'b1,4'd14,32'hEE,     1'b1,4'd8,1'b1,1'b0,1'b0,4'd0, 32'h0,        16'h0000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd0, 32'h0,        16'h0000,1'b1});
        // flush with empty FIFO kills the incoming ALU result
        vecs.push_back('{1'b0,1'b1,1'b1,4'd9,32'h55,       1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b0,1'b0,4'd0, 32'h0,        16'h0000,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd0, 32'h0,      1'b0,4'd0,1'b1,1'b1,1'b0,4'd0, 32'h0,        16'h0000,1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset            = vecs[i].rst;
            flush            = vecs[i].fl;
            alu_result_valid = vecs[i].av;
            alu_result_dest  = vecs[i].ad;
            alu_result_data  = vecs[i].adat;
            mem_result_valid = vecs[i].mv;
            mem_result_dest  = vecs[i].md;
            mem_result_data  = vecs[i].mdat;
            load_issue       = vecs[i].li;
            load_issue_dest  = vecs[i].lid;
            #1;
            if (vecs[i].chk_rdy)
                chk($sformatf("v%0d ready", i), 32'(alu_result_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d we", i),   32'(port_write_enable), 32'(vecs[i].e_we));
            chk($sformatf("v%0d addr", i), 32'(port_write_addr),   32'(vecs[i].e_addr));
            chk($sformatf("v%0d data", i), port_write_data,        vecs[i].e_data);
            chk($sformatf("v%0d busy", i), 32'(reg_busy),          32'(vecs[i].e_busy));
            chk($sformatf("v%0d idle", i), 32'(wb_idle),           32'(vecs[i].e_idle));
        end

        // Back-to-back bypass burst: one write per cycle, each one cycle after acceptance.
        for (int k = 0; k < 3; k++) begin
            int t;
            @(negedge clk);
            reset            = 1'b0;
            flush            = 1'b0;
            mem_result_valid = 1'b0;
            load_issue       = 1'b0;
            alu_result_valid = 1'b1;
            alu_result_dest  = 4'(k + 1);
            alu_result_data  = 32'hC0DE0000 | 32'(k);
            t = 0;
            while (!alu_result_ready && t < 8) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("burst%0d ready", k), 32'(alu_result_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d we", k),   32'(port_write_enable), 32'd1);
            chk($sformatf("burst%0d addr", k), 32'(port_write_addr),   32'(k + 1));
            chk($sformatf("burst%0d data", k), port_write_data,        32'hC0DE0000 | 32'(k));
        end
        @(negedge clk);
        alu_result_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("burst end we",   32'(port_write_enable), 32'd0);
        chk("burst end idle", 32'(wb_idle),           32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
